cpu_ctrl_seq: RTL and testbench

- Hardwired microsequencer for the accumulator CPU.
- Walks each instruction through fetch, decode and execute states.
- Drives the one-hot datapath strobes C0..C11, the ALU op and status flags. This includes C7, the MBR-to-BR operand load.
- Sits between the IR/ACC datapath and the memory port, and owns the memory-ready handshake and its timeout.

---
 rtl/cpu_ctrl_seq_if.sv | 26 ++
 rtl/cpu_ctrl_seq.sv | 148 ++++++++++++++
 tb/tb_cpu_ctrl_seq.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_seq_if.sv
// Sequencer <-> datapath/memory signal bundle: opcode, sign and memory-ready in,
// one-hot strobes, ALU op and status flags out.
interface cpu_ctrl_seq_if #(
    parameter int OPW = 8
);
    logic           start;
    logic [OPW-1:0] ir_opcode;
    logic           acc_sign;
    logic           mem_ready;
    logic [11:0]    ctrl;
    logic [2:0]     alu_op;
    logic           busy;
    logic           halted;
    logic           mem_err;
    logic           illegal;

    modport master (
        input  start, ir_opcode, acc_sign, mem_ready,
        output ctrl, alu_op, busy, halted, mem_err, illegal
    );

    modport slave (
        output start, ir_opcode, acc_sign, mem_ready,
        input  ctrl, alu_op, busy, halted, mem_err, illegal
    );
endinterface

// File: rtl/cpu_ctrl_seq.sv
// Hardwired fetch/decode/execute microsequencer for the accumulator CPU (optional macro CU_STEP_EN adds single-step PAUSE).
// Latency: Moore outputs from the state register; NOP 4, JMP 5, STORE 7, ADD/SUB 8, LOAD 9 cycles at zero wait.
// Backpressure: memory states hold on mem_ready=0 and fault after MEM_TIMEOUT wait cycles.
module cpu_ctrl_seq #(
    parameter int MEM_TIMEOUT = 15,
    parameter int OPW         = 8
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef CU_STEP_EN
    input  logic          step,
`endif
    cpu_ctrl_seq_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_F0, S_F1, S_F2, S_D0,
        S_MA, S_ST_MBR, S_ST_WR, S_RD, S_BR, S_CLR, S_ALU, S_JMP,
        S_HALT, S_FAULT
`ifdef CU_STEP_EN
        , S_PAUSE
`endif
    } state_t;

    typedef enum logic [1:0] {K_STORE, K_LOAD, K_ADD, K_SUB} kind_t;

    // Where a finished instruction goes to start the next fetch.
`ifdef CU_STEP_EN
    localparam state_t S_NEXT = S_PAUSE;
`else
    localparam state_t S_NEXT = S_F0;
`endif

    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    kind_t      kind_q, kind_d;
    logic [7:0] cnt_q, cnt_d;
    logic       illegal_q, illegal_d;
    logic       in_wait;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            kind_q    <= K_STORE;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            kind_q    <= kind_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        cnt_d     = '0;
        illegal_d = illegal_q;
        in_wait   = 1'b0;

        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_F0;
            S_F0:     state_d = S_F1;
            S_F1: begin
                in_wait = 1'b1;
                state_d = S_F2;
            end
            S_F2:     state_d = S_D0;
            S_D0: begin
                case (bus.ir_opcode)
                    OPW'(8'h00): state_d = S_NEXT;
                    OPW'(8'h01): begin kind_d = K_STORE; state_d = S_MA; end
                    OPW'(8'h02): begin kind_d = K_LOAD;  state_d = S_MA; end
                    OPW'(8'h03): begin kind_d = K_ADD;   state_d = S_MA; end
                    OPW'(8'h04): begin kind_d = K_SUB;   state_d = S_MA; end
                    OPW'(8'h05): state_d = S_JMP;
                    OPW'(8'h06): state_d = bus.acc_sign ? S_NEXT : S_JMP;
                    OPW'(8'h07): state_d = S_HALT;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_MA:     state_d = (kind_q == K_STORE) ? S_ST_MBR : S_RD;
            S_ST_MBR: state_d = S_ST_WR;
            S_ST_WR: begin
                in_wait = 1'b1;
                state_d = S_NEXT;
            end
            S_RD: begin
                in_wait = 1'b1;
                state_d = S_BR;
            end
            S_BR:     state_d = (kind_q == K_LOAD) ? S_CLR : S_ALU;
            S_CLR:    state_d = S_ALU;
            S_ALU:    state_d = S_NEXT;
            S_JMP:    state_d = S_NEXT;
`ifdef CU_STEP_EN
            S_PAUSE:  if (step) state_d = S_F0;
`endif
            default:  state_d = state_q;
        endcase

        // Ready on the limit cycle still advances; only a missing ready faults.
        if (in_wait && !bus.mem_ready) begin
            if (cnt_q == WAIT_LIMIT) begin
                state_d = S_FAULT;
            end else begin
                state_d = state_q;
                cnt_d   = cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        bus.ctrl    = '0;
        bus.alu_op  = 3'b000;
        bus.busy    = !(state_q inside {S_IDLE, S_HALT, S_FAULT});
        bus.halted  = (state_q == S_HALT) || (state_q == S_FAULT);
        bus.mem_err = (state_q == S_FAULT);
        bus.illegal = illegal_q;

        case (state_q)
            S_F0:     bus.ctrl[0]  = 1'b1;
            S_F1:     bus.ctrl[2]  = 1'b1;
            S_F2: begin
                bus.ctrl[3] = 1'b1;
                bus.ctrl[1] = 1'b1;
            end
            S_MA:     bus.ctrl[4]  = 1'b1;
            S_ST_MBR: bus.ctrl[6]  = 1'b1;
            S_ST_WR:  bus.ctrl[5]  = 1'b1;
            S_RD:     bus.ctrl[2]  = 1'b1;
            S_BR:     bus.ctrl[7]  = 1'b1;
            S_CLR:    bus.ctrl[8]  = 1'b1;
            S_ALU: begin
                bus.ctrl[9] = 1'b1;
                bus.alu_op  = (kind_q == K_SUB) ? 3'b010 : 3'b001;
            end
            S_JMP:    bus.ctrl[10] = 1'b1;
            default:  bus.ctrl     = '0;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Directed bench for cpu_ctrl_seq: per-cycle strobe sequences, memory waits, timeout, illegal opcode, reset.
module tb_cpu_ctrl_seq;

    logic clk = 1'b0;
    logic rst_n;
`ifdef CU_STEP_EN
    logic step;
`endif

    always #5 clk = ~clk;

    cpu_ctrl_seq_if #(.OPW(8)) bus ();

    cpu_ctrl_seq #(
        .MEM_TIMEOUT(4),
        .OPW        (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
`ifdef CU_STEP_EN
        .step (step),
`endif
        .bus  (bus)
    );

    int n_run  = 0;
    int n_fail = 0;

    // Strobes seen in the cycle after an instruction completes: F0, or PAUSE when stepping.
`ifdef CU_STEP_EN
    localparam logic [11:0] NXT = 12'h000;
`else
    localparam logic [11:0] NXT = 12'h001;
`endif

    localparam logic [7:0] OPS   [8] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h06};
    localparam logic       SIGNS [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam int         LENS  [8] = '{5, 8, 10, 9, 9, 6, 6, 5};
    localparam logic [11:0] SEQ [8][10] = '{
        '{12'h001, 12'h004, 12'h00A, 12'h000, NXT,     12'h000, 12'h000, 12'h000, 12'h000, 12'h000},
        '{12'h001, 12'h004, 12'h00A, 12'h000, 12'h010, 12'h040, 12'h020, NXT,     12'h000, 12'h000},
        '{12'h001, 12'h004, 12'h00A, 12'h000, 12'h010, 12'h004, 12'h080, 12'h100, 12'h200, NXT    },
        '{12'h001, 12'h004, 12'h00A, 12'h000, 12'h010, 12'h004, 12'h080, 12'h200, NXT,     12'h000},
        '{12'h001, 12'h004, 12'h00A, 12'h000, 12'h010, 12'h004, 12'h080, 12'h200, NXT,     12'h000},
        '{12'h001, 12'h004, 12'h00A, 12'h000, 12'h400, NXT,     12'h000, 12'h000, 12'h000, 12'h000},
        '{12'h001, 12'h004, 12'h00A, 12'h000, 12'h400, NXT,     12'h000, 12'h000, 12'h000, 12'h000},
        '{12'h001, 12'h004, 12'h00A, 12'h000, NXT,     12'h000, 12'h000, 12'h000, 12'h000, 12'h000}
    };

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reset, then pulse start; returns sampled in the first F0.
    task automatic begin_instr(input logic [7:0] op, input logic sign);
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.mem_ready = 1'b1;
        bus.ir_opcode = op;
        bus.acc_sign  = sign;
        tick;
        rst_n     = 1'b1;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.mem_ready = 1'b0;
        bus.ir_opcode = 8'h00;
        bus.acc_sign  = 1'b0;
        tick;
        tick;
        n_run++;
        if ({bus.ctrl, bus.alu_op, bus.busy, bus.halted, bus.mem_err, bus.illegal} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_state: got ctrl=%h alu=%b busy=%b halted=%b mem_err=%b illegal=%b, want all 0",
                     bus.ctrl, bus.alu_op, bus.busy, bus.halted, bus.mem_err, bus.illegal);
        end
        rst_n = 1'b1;
        tick;
        n_run++;
        if ({bus.ctrl, bus.busy} !== 13'd0) begin
            n_fail++;
            $display("FAIL idle_hold: got ctrl=%h busy=%b, want ctrl=000 busy=0", bus.ctrl, bus.busy);
        end
    endtask

    task automatic test_exec_ops;
        logic [11:0] exp_c;
        logic [2:0]  exp_a;
        for (int t = 0; t < 8; t++) begin
            begin_instr(OPS[t], SIGNS[t]);
            for (int i = 0; i < LENS[t]; i++) begin
                exp_c = SEQ[t][i];
                exp_a = exp_c[9] ? ((OPS[t] == 8'h04) ? 3'b010 : 3'b001) : 3'b000;
                n_run++;
                if ({bus.ctrl, bus.alu_op, bus.busy} !== {exp_c, exp_a, 1'b1}) begin
                    n_fail++;
                    $display("FAIL exec op=%h sign=%b cyc%0d: got ctrl=%h alu=%b busy=%b, want ctrl=%h alu=%b busy=1",
                             OPS[t], SIGNS[t], i, bus.ctrl, bus.alu_op, bus.busy, exp_c, exp_a);
                end
                tick;
            end
        end
    endtask

    task automatic test_add_wait;
        logic [11:0] exp_c [12];
        logic [2:0]  exp_a;
        exp_c = '{12'h001, 12'h004, 12'h00A, 12'h000, 12'h010, 12'h004,
                  12'h004, 12'h004, 12'h004, 12'h080, 12'h200, NXT};
        begin_instr(8'h03, 1'b0);
        for (int i = 0; i < 12; i++) begin
            exp_a = (i == 10) ? 3'b001 : 3'b000;
            n_run++;
            if ({bus.ctrl, bus.alu_op, bus.busy} !== {exp_c[i], exp_a, 1'b1}) begin
                n_fail++;
                $display("FAIL add_wait cyc%0d: got ctrl=%h alu=%b busy=%b, want ctrl=%h alu=%b busy=1",
                         i, bus.ctrl, bus.alu_op, bus.busy, exp_c[i], exp_a);
            end
            bus.mem_ready = !(i >= 5 && i <= 7);
            tick;
        end
    endtask

    task automatic test_timeout;
        // Fetch wait: four C2 cycles, then FAULT.
        begin_instr(8'h00, 1'b0);
        bus.mem_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick;
            n_run++;
            if ({bus.ctrl, bus.busy, bus.mem_err} !== {12'h004, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL fetch_wait cyc%0d: got ctrl=%h busy=%b mem_err=%b, want ctrl=004 busy=1 mem_err=0",
                         i, bus.ctrl, bus.busy, bus.mem_err);
            end
        end
        tick;
        bus.start     = 1'b1;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_run++;
            if ({bus.ctrl, bus.busy, bus.halted, bus.mem_err} !== {12'h000, 1'b0, 1'b1, 1'b1}) begin
                n_fail++;
                $display("FAIL fetch_fault%0d: got ctrl=%h busy=%b halted=%b mem_err=%b, want ctrl=000 busy=0 halted=1 mem_err=1",
                         i, bus.ctrl, bus.busy, bus.halted, bus.mem_err);
            end
            tick;
        end
        // Execute write wait: STORE E2 holds C5 four cycles, then FAULT.
        begin_instr(8'h01, 1'b0);
        repeat (6) tick;
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_run++;
            if (bus.ctrl !== 12'h020) begin
                n_fail++;
                $display("FAIL store_wait cyc%0d: got ctrl=%h, want ctrl=020", i, bus.ctrl);
            end
            tick;
        end
        n_run++;
        if ({bus.ctrl, bus.halted, bus.mem_err} !== {12'h000, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL store_fault: got ctrl=%h halted=%b mem_err=%b, want ctrl=000 halted=1 mem_err=1",
                     bus.ctrl, bus.halted, bus.mem_err);
        end
    endtask

    task automatic test_illegal;
        begin_instr(8'hAB, 1'b0);
        repeat (4) tick;
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_run++;
            if ({bus.ctrl, bus.busy, bus.halted, bus.mem_err, bus.illegal} !== {12'h000, 1'b0, 1'b1, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL illegal%0d: got ctrl=%h busy=%b halted=%b mem_err=%b illegal=%b, want 000/0/1/0/1",
                         i, bus.ctrl, bus.busy, bus.halted, bus.mem_err, bus.illegal);
            end
            tick;
        end
        rst_n     = 1'b0;
        bus.start = 1'b0;
        tick;
        n_run++;
        if ({bus.halted, bus.illegal} !== 2'b00) begin
            n_fail++;
            $display("FAIL illegal_clear: got halted=%b illegal=%b, want 0 0", bus.halted, bus.illegal);
        end
        begin_instr(8'h07, 1'b0);
        repeat (4) tick;
        n_run++;
        if ({bus.ctrl, bus.busy, bus.halted, bus.illegal} !== {12'h000, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL halt_op: got ctrl=%h busy=%b halted=%b illegal=%b, want 000/0/1/0",
                     bus.ctrl, bus.busy, bus.halted, bus.illegal);
        end
    endtask

    task automatic test_reset_mid_wait;
        begin_instr(8'h03, 1'b0);
        repeat (4) tick;
        bus.mem_ready = 1'b0;
        tick;
        tick;
        n_run++;
        if (bus.ctrl !== 12'h004) begin
            n_fail++;
            $display("FAIL e1_wait: got ctrl=%h, want ctrl=004", bus.ctrl);
        end
        rst_n = 1'b0;
        tick;
        n_run++;
        if ({bus.ctrl, bus.alu_op, bus.busy, bus.halted, bus.mem_err, bus.illegal} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_mid_wait: got ctrl=%h alu=%b busy=%b halted=%b mem_err=%b illegal=%b, want all 0",
                     bus.ctrl, bus.alu_op, bus.busy, bus.halted, bus.mem_err, bus.illegal);
        end
        rst_n         = 1'b1;
        bus.mem_ready = 1'b1;
        bus.start     = 1'b1;
        tick;
        bus.start = 1'b0;
        n_run++;
        if ({bus.ctrl, bus.busy} !== {12'h001, 1'b1}) begin
            n_fail++;
            $display("FAIL restart: got ctrl=%h busy=%b, want ctrl=001 busy=1", bus.ctrl, bus.busy);
        end
    endtask

`ifdef CU_STEP_EN
    task automatic test_pause;
        step = 1'b0;
        begin_instr(8'h00, 1'b0);
        repeat (4) tick;
        for (int i = 0; i < 5; i++) begin
            n_run++;
            if ({bus.ctrl, bus.busy} !== {12'h000, 1'b1}) begin
                n_fail++;
                $display("FAIL pause%0d: got ctrl=%h busy=%b, want ctrl=000 busy=1", i, bus.ctrl, bus.busy);
            end
            tick;
        end
        step = 1'b1;
        tick;
        step = 1'b0;
        n_run++;
        if (bus.ctrl !== 12'h001) begin
            n_fail++;
            $display("FAIL pause_exit: got ctrl=%h, want ctrl=001", bus.ctrl);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef CU_STEP_EN
        step = 1'b0;
`endif
        test_reset;
        test_exec_ops;
        test_add_wait;
        test_timeout;
        test_illegal;
        test_reset_mid_wait;
`ifdef CU_STEP_EN
        test_pause;
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
